// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks a {reg_addr,reg_data} config ROM and issues one SCCB write per entry; SCCB_INIT_VERIFY_EN adds readback verify with retries
module sccb_init_seq #(
  parameter int          TBL_AW         = 8,
  parameter int unsigned PWRUP_CYCLES   = 1024,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned DELAY_UNIT     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_init_done,
  output logic              o_err,
  output logic [TBL_AW-1:0] o_err_idx,
  output logic [TBL_AW-1:0] o_tbl_addr,
  input  logic [15:0]       i_tbl_data,
  output logic              o_sccb_valid,
  output logic              o_sccb_rd,
  output logic [7:0]        o_sccb_addr,
  output logic [7:0]        o_sccb_wdata,
  input  logic              i_sccb_done,
  input  logic [7:0]        i_sccb_rdata
);
  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE, S_DELAY, S_GAP, S_NEXT, S_DONE, S_VERIFY
  } state_t;
  state_t            r_state, w_state;
  logic [31:0]       r_cnt, w_cnt;
  logic [7:0]        r_tick, w_tick;
  logic [15:0]       r_entry, w_entry;
  logic [TBL_AW-1:0] r_addr, w_addr, r_err_idx, w_err_idx;
  logic              r_busy, w_busy, r_done, w_done, r_err, w_err, r_valid, w_valid;
  logic [7:0]        r_saddr, w_saddr, r_wdata, w_wdata;
  logic              w_fail;
`ifdef SCCB_INIT_VERIFY_EN
  logic              r_rd, w_rd;
  logic [1:0]        r_ph, w_ph;
  logic [31:0]       r_retry, w_retry;
  assign o_sccb_rd = r_rd;
`else
  logic              w_unused;
  assign w_unused  = ^{i_sccb_rdata, MAX_RETRY};
  assign o_sccb_rd = 1'b0;
`endif
  assign o_busy       = r_busy;
  assign o_init_done  = r_done;
  assign o_err        = r_err;
  assign o_err_idx    = r_err_idx;
  assign o_tbl_addr   = r_addr;
  assign o_sccb_valid = r_valid;
  assign o_sccb_addr  = r_saddr;
  assign o_sccb_wdata = r_wdata;

  // next-state and next-output logic; any failure funnels through w_fail
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_tick    = r_tick;
    w_entry   = r_entry;
    w_addr    = r_addr;
    w_err_idx = r_err_idx;
    w_busy    = r_busy;
    w_done    = r_done;
    w_err     = r_err;
    w_valid   = r_valid;
    w_saddr   = r_saddr;
    w_wdata   = r_wdata;
    w_fail    = 1'b0;
`ifdef SCCB_INIT_VERIFY_EN
    w_rd      = r_rd;
    w_ph      = r_ph;
    w_retry   = r_retry;
`endif
    case (r_state)
      S_IDLE: if (i_start) begin
        w_state = S_PWRUP;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_addr  = '0;
        w_cnt   = '0;
      end
      S_PWRUP: begin
        w_cnt = r_cnt + 32'd1;
        if (r_cnt == PWRUP_CYCLES - 1) begin
          w_cnt   = '0;
          w_state = S_FETCH;
        end
      end
      S_FETCH: w_state = S_DECODE;
      S_DECODE: begin
        w_entry = i_tbl_data;
        w_cnt   = '0;
        w_tick  = '0;
`ifdef SCCB_INIT_VERIFY_EN
        w_retry = '0;
        w_ph    = 2'd0;
        w_rd    = 1'b0;
`endif
        if (i_tbl_data == 16'hFFFF) w_state = S_DONE;
        else if (i_tbl_data[15:8] == 8'hF0) w_state = S_DELAY;
        else begin
          w_state = S_ISSUE;
          w_valid = 1'b1;
          w_saddr = i_tbl_data[15:8];
          w_wdata = i_tbl_data[7:0];
        end
      end
      S_ISSUE, S_VERIFY: begin
        w_cnt = r_cnt + 32'd1;
        if (i_sccb_done) begin
          w_valid = 1'b0;
          w_cnt   = '0;
          w_state = S_GAP;
`ifdef SCCB_INIT_VERIFY_EN
          w_ph = 2'd0;
          if (r_state == S_VERIFY) begin
            w_rd = 1'b0;
            w_ph = (i_sccb_rdata == r_entry[7:0]) ? 2'd1 : 2'd2;
            if (i_sccb_rdata != r_entry[7:0]) begin
              if (r_retry == MAX_RETRY) w_fail = 1'b1;
              else w_retry = r_retry + 32'd1;
            end
          end
`endif
        end else if (r_cnt == TIMEOUT_CYCLES - 1) w_fail = 1'b1;
      end
      S_DELAY: begin
        w_cnt = r_cnt + 32'd1;
        if (r_tick == r_entry[7:0]) w_state = S_NEXT;
        else if (r_cnt == DELAY_UNIT - 1) begin
          w_cnt  = '0;
          w_tick = r_tick + 8'd1;
        end
      end
      S_GAP: begin
        w_cnt = r_cnt + 32'd1;
        if (r_cnt == GAP_CYCLES - 1) begin
          w_cnt   = '0;
          w_state = S_NEXT;
`ifdef SCCB_INIT_VERIFY_EN
          if (r_ph == 2'd0 && r_saddr != 8'h12) begin
            w_state = S_VERIFY;
            w_valid = 1'b1;
            w_rd    = 1'b1;
          end else if (r_ph == 2'd2) begin
            w_state = S_ISSUE;
            w_valid = 1'b1;
            w_ph    = 2'd0;
          end
`endif
        end
      end
      S_NEXT: begin
        if (&r_addr) w_fail = 1'b1;
        else begin
          w_addr  = r_addr + TBL_AW'(1);
          w_state = S_FETCH;
        end
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    if (w_fail) begin
      w_valid   = 1'b0;
      w_err     = 1'b1;
      w_busy    = 1'b0;
      w_err_idx = r_addr;
      w_state   = S_IDLE;
`ifdef SCCB_INIT_VERIFY_EN
      w_rd      = 1'b0;
`endif
    end
  end

  // state and output registers; async reset drops any in-flight request at once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tick    <= '0;
      r_entry   <= '0;
      r_addr    <= '0;
      r_err_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
      r_saddr   <= '0;
      r_wdata   <= '0;
`ifdef SCCB_INIT_VERIFY_EN
      r_rd      <= 1'b0;
      r_ph      <= '0;
      r_retry   <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_tick    <= w_tick;
      r_entry   <= w_entry;
      r_addr    <= w_addr;
      r_err_idx <= w_err_idx;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_err     <= w_err;
      r_valid   <= w_valid;
      r_saddr   <= w_saddr;
      r_wdata   <= w_wdata;
`ifdef SCCB_INIT_VERIFY_EN
      r_rd      <= w_rd;
      r_ph      <= w_ph;
      r_retry   <= w_retry;
`endif
    end
  end
endmodule

// File: doc/sccb_init_seq.md
Name: sccb_init_seq

Overview:
- Table-driven register-initialisation sequencer for the OV7725 camera.
- Walks an external synchronous ROM of {reg_addr, reg_data} entries and issues one SCCB write per entry to the SCCB master engine.
- Supports timed-delay entries and an end marker; reports completion and errors to the DCMI/system controller.
- Sits between the system start logic, the config ROM and the SCCB master.

Parameters:
TBL_AW, 8, ROM address width; table holds at most 2^TBL_AW entries
PWRUP_CYCLES, 1024, clk cycles waited after start before the first fetch
GAP_CYCLES, 16, idle clk cycles between consecutive SCCB transactions
DELAY_UNIT, 1000, clk cycles per delay-entry tick
TIMEOUT_CYCLES, 4096, max cycles from issue to sccb_done before error
MAX_RETRY, 3, verify retries per entry (VERIFY_EN only)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins sequence when idle
busy  out  1  high from accepted start until init_done or err
init_done  out  1  level; set at end marker, cleared on next accepted start
err  out  1  level; set on timeout/verify failure, cleared on next accepted start
err_idx  out  TBL_AW  table index of the failing entry
tbl_addr  out  TBL_AW  ROM address
tbl_data  in  16  ROM data {reg_addr[15:8], reg_data[7:0]}; valid 1 cycle after tbl_addr changes
sccb_valid  out  1  request to SCCB master
sccb_rd  out  1  0 = write transaction, 1 = read transaction
sccb_addr  out  8  register address
sccb_wdata  out  8  write data
sccb_done  in  1  one-cycle pulse at end of the SCCB transaction
sccb_rdata  in  8  read data, valid when sccb_done is high

Behaviour:
- Reset: all outputs 0, state IDLE, tbl_addr = 0.
- IDLE: on start -> clear init_done/err, tbl_addr = 0, busy = 1 -> PWRUP. start is ignored while busy.
- PWRUP: count PWRUP_CYCLES -> FETCH.
- FETCH: drive tbl_addr, wait 1 cycle -> DECODE; register tbl_data.
- DECODE, on the registered entry:
  - 0xFFFF (end marker) -> DONE.
  - reg_addr = 0xF0 (delay entry) -> DELAY.
  - Otherwise -> ISSUE.
- ISSUE: sccb_valid = 1, sccb_rd = 0, sccb_addr/sccb_wdata = entry.
  - All four outputs held stable until sccb_done.
  - sccb_valid cleared on the same edge that samples sccb_done = 1, so the master never sees a held request when it re-enters idle.
  - Then -> GAP.
  - If TIMEOUT_CYCLES elapse without sccb_done: drop sccb_valid, err = 1, err_idx = tbl_addr -> IDLE.
- DELAY: wait reg_data * DELAY_UNIT cycles.
  - Nested counters: tick counter 0..DELAY_UNIT-1, plus 8-bit tick count.
  - reg_data = 0 gives zero wait.
  - Then -> NEXT.
- GAP: wait GAP_CYCLES -> NEXT.
- NEXT: tbl_addr + 1.
  - If tbl_addr was 2^TBL_AW-1 (no end marker found): err = 1, err_idx = tbl_addr -> IDLE.
  - Otherwise -> FETCH.
- DONE: init_done = 1, busy = 0 -> IDLE.
- On any error, busy = 0 in the same cycle err rises.
- Reset mid-transaction: sccb_valid drops immediately (async). The sequence is not resumed; a new start is required.
- sccb_done outside ISSUE/VERIFY is ignored.

Optional Feature:
- Macro SCCB_INIT_VERIFY_EN.
- Defined:
  - After each write's GAP, issue a read: sccb_rd = 1, same sccb_addr, same handshake and timeout rules.
  - Compare sccb_rdata with reg_data.
  - Match -> GAP -> NEXT.
  - Mismatch -> re-issue the write, up to MAX_RETRY times; then err = 1, err_idx = entry index.
  - Entries with reg_addr = 0x12 (software reset register) are never verified.
- Not defined: sccb_rd is tied to 0, no read or compare logic, no retry counter.

Test Plan:
- Table {0x12_80, 0xF0_02, 0x11_01, 0xFFFF}, PWRUP_CYCLES = 16, DELAY_UNIT = 10, start -> writes (0x12,0x80) then (0x11,0x01); ≥20 cycles between first done and second issue; init_done = 1, busy = 0, err = 0.
- Master model holds done for 40 cycles per request -> sccb_valid/addr/wdata stable the entire time; sccb_valid = 0 on the cycle after the done pulse; exactly one request per entry.
- TIMEOUT_CYCLES = 64, master never pulses done on entry 1 -> err = 1, err_idx = 1, sccb_valid = 0, busy = 0; next start clears err and restarts from index 0.
- Table with no end marker, TBL_AW = 2 -> 4 writes, then err = 1, err_idx = 3.
- Async reset asserted while sccb_valid = 1 -> all outputs 0 immediately; extra start pulses during busy have no effect.
- VERIFY_EN: readback returns 0x00 for a write of 0x55 -> 1 + MAX_RETRY writes, err = 1; correct readback -> write + read per entry, then init_done.
